// File: rtl/conv2d_systolic_param.sv
// Parametrised 2-D valid convolution engine.
// PES MAC lanes share one broadcast filter tap per cycle.
module conv2d_systolic_param #(
    parameter int DW        = 8,
    parameter int IMG_N     = 4,
    parameter int K         = 3,
    parameter int PES       = 4,
    parameter int OUT_SHIFT = 0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       sat_mode,
    input  logic [IMG_N*IMG_N*DW-1:0]                  img,
    input  logic [K*K*DW-1:0]                          flt,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       out_valid,
    output logic [(IMG_N-K+1)*(IMG_N-K+1)*DW-1:0]      res
);

    localparam int O     = IMG_N - K + 1;
    localparam int NO    = O * O;
    localparam int KK    = K * K;
    localparam int ACC_W = 2 * DW + $clog2(KK);
    localparam int G     = (NO + PES - 1) / PES;
    localparam int TW    = (KK > 1) ? $clog2(KK) : 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int IW    = $clog2(IMG_N * IMG_N * DW);
    localparam int FW    = (KK * DW > 1) ? $clog2(KK * DW) : 1;
    localparam int RW    = (NO > 1) ? $clog2(NO) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_FIN
    } state_t;

    state_t                  state;
    logic [IMG_N*IMG_N*DW-1:0] img_q;
    logic [KK*DW-1:0]        flt_q;
    logic                    sat_q;
    logic [GW-1:0]           grp;
    logic [TW-1:0]           tap;
    logic [ACC_W-1:0]        acc [PES];
    logic [DW-1:0]           res_w [NO];

    logic [DW-1:0]           tap_v;
    logic [DW-1:0]           pix [PES];
    logic                    lane_on [PES];

    // Output index handled by lane l within group g.
    function automatic int lane_idx(input logic [GW-1:0] g, input int l);
        return int'(g) * PES + l;
    endfunction

    // Bit offset of the pixel under filter tap t for output index n.
    function automatic int pix_pos(input int n, input int t);
        return ((n / O + t / K) * IMG_N + n % O + t % K) * DW;
    endfunction

    // Scale the accumulator, then saturate or truncate to DW bits.
    function automatic logic [DW-1:0] shape(
        input logic [ACC_W-1:0] a,
        input logic             sat
    );
        logic [ACC_W-1:0] v;
        v = a >> OUT_SHIFT;
        if (sat && (v > ACC_W'({DW{1'b1}}))) begin
            return '1;
        end
        return v[DW-1:0];
    endfunction

    // Broadcast tap and per-lane pixel selection for the current cycle.
    always_comb begin
        tap_v = flt_q[FW'(int'(tap) * DW) +: DW];
        for (int l = 0; l < PES; l++) begin
            lane_on[l] = (lane_idx(grp, l) < NO);
            pix[l]     = '0;
            if (lane_on[l]) begin
                pix[l] = img_q[IW'(pix_pos(lane_idx(grp, l), int'(tap))) +: DW];
            end
        end
    end

    // Control FSM, operand capture, MAC lanes and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            img_q     <= '0;
            flt_q     <= '0;
            sat_q     <= 1'b0;
            grp       <= '0;
            tap       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            for (int l = 0; l < PES; l++) begin
                acc[l] <= '0;
            end
            for (int n = 0; n < NO; n++) begin
                res_w[n] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        img_q     <= img;
                        flt_q     <= flt;
                        sat_q     <= sat_mode;
                        grp       <= '0;
                        tap       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b1;
                        for (int l = 0; l < PES; l++) begin
                            acc[l] <= '0;
                        end
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    for (int l = 0; l < PES; l++) begin
                        acc[l] <= acc[l] + ACC_W'(pix[l]) * ACC_W'(tap_v);
                    end
                    if (tap == TW'(KK - 1)) begin
                        state <= S_WRITE;
                    end else begin
                        tap <= tap + TW'(1);
                    end
                end
                S_WRITE: begin
                    for (int l = 0; l < PES; l++) begin
                        if (lane_on[l]) begin
                            res_w[RW'(lane_idx(grp, l))] <= shape(acc[l], sat_q);
                        end
                        acc[l] <= '0;
                    end
                    tap <= '0;
                    if (grp == GW'(G - 1)) begin
                        done      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_FIN;
                    end else begin
                        grp   <= grp + GW'(1);
                        state <= S_MAC;
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Flatten the result words onto the output bus.
    for (genvar n = 0; n < NO; n++) begin : g_res
        assign res[n*DW +: DW] = res_w[n];
    end

endmodule

// File: tb/tb_conv2d_systolic_param.sv
// Self-checking bench: several builds run side by side against
// a plain-arithmetic convolution model.
module tb_conv2d_systolic_param;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sat = 1'b0;
    logic [127:0] img4 = '0;
    logic [287:0] img6 = '0;
    logic [71:0]  flt = '0;
    logic [5:0]   busy_v;
    logic [5:0]   done_v;
    logic [5:0]   ov_v;
    logic [31:0]  r4, r1, r2, r3, rs;
    logic [127:0] r6;

    int img_m [6][6];
    int flt_m [3][3];
    int checks = 0;
    int errors = 0;

    int exp_done [6] = '{11, 41, 21, 21, 41, 11};
    int t1_img [4][4] = '{'{9, 8, 2, 6}, '{0, 4, 1, 6},
                          '{4, 10, 1, 1}, '{2, 2, 9, 9}};
    int t1_flt [3][3] = '{'{3, 2, 0}, '{2, 0, 1}, '{3, 1, 1}};

    always #5 clk = ~clk;

    conv2d_systolic_param u4 (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat),
        .img(img4), .flt(flt), .busy(busy_v[0]), .done(done_v[0]),
        .out_valid(ov_v[0]), .res(r4));
    conv2d_systolic_param #(.PES(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat),
        .img(img4), .flt(flt), .busy(busy_v[1]), .done(done_v[1]),
        .out_valid(ov_v[1]), .res(r1));
    conv2d_systolic_param #(.PES(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat),
        .img(img4), .flt(flt), .busy(busy_v[2]), .done(done_v[2]),
        .out_valid(ov_v[2]), .res(r2));
    conv2d_systolic_param #(.PES(3)) u3 (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat),
        .img(img4), .flt(flt), .busy(busy_v[3]), .done(done_v[3]),
        .out_valid(ov_v[3]), .res(r3));
    conv2d_systolic_param #(.IMG_N(6)) u6 (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat),
        .img(img6), .flt(flt), .busy(busy_v[4]), .done(done_v[4]),
        .out_valid(ov_v[4]), .res(r6));
    conv2d_systolic_param #(.OUT_SHIFT(3)) us (
        .clk(clk), .rst(rst), .start(start), .sat_mode(sat),
        .img(img4), .flt(flt), .busy(busy_v[5]), .done(done_v[5]),
        .out_valid(ov_v[5]), .res(rs));

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_ops();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                img6[9'((r * 6 + c) * 8) +: 8] = 8'(img_m[r][c]);
                if (r < 4 && c < 4) begin
                    img4[7'((r * 4 + c) * 8) +: 8] = 8'(img_m[r][c]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                flt[7'((i * 3 + j) * 8) +: 8] = 8'(flt_m[i][j]);
            end
        end
    endtask

    task automatic set_rand_img();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                img_m[r][c] = int'($urandom_range(0, 255));
            end
        end
        pack_ops();
    endtask

    task automatic set_rand();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                flt_m[i][j] = int'($urandom_range(0, 255));
            end
        end
        set_rand_img();
    endtask

    task automatic set_t1();
        set_rand_img();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                img_m[r][c] = t1_img[r][c];
            end
        end
        flt_m = t1_flt;
        pack_ops();
    endtask

    task automatic set_all(input int v);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                img_m[r][c] = v;
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                flt_m[i][j] = v;
            end
        end
        pack_ops();
    endtask

    // Valid 3x3 convolution of the top-left n x n image window.
    function automatic logic [127:0] model(input int n, input int sh,
                                           input bit s);
        logic [127:0] v;
        longint acc;
        longint w;
        int o;
        v = '0;
        o = n - 2;
        for (int r = 0; r < o; r++) begin
            for (int c = 0; c < o; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        acc += longint'(img_m[r + i][c + j]) * flt_m[i][j];
                    end
                end
                acc = acc >> sh;
                if (s) w = (acc > 255) ? 255 : acc;
                else   w = acc % 256;
                v[7'((r * o + c) * 8) +: 8] = 8'(w);
            end
        end
        return v;
    endfunction

    // mode 0 plain, 1 restart attempt mid-run, 2 start in DONE cycle,
    // 3 reset mid-run.
    task automatic run(input int mode, input string tag);
        logic [127:0] e4, e6, es;
        int first [6];
        int cnt [6];
        bit hs [6];
        bit b, o;
        e4 = model(4, 0, sat);
        e6 = model(6, 0, sat);
        es = model(4, 3, sat);
        for (int k = 0; k < 6; k++) begin
            first[k] = 0;
            cnt[k] = 0;
            hs[k] = 1'b1;
        end
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (done_v[k] === 1'b1) begin
                    cnt[k]++;
                    if (first[k] == 0) first[k] = cyc;
                end
                b = (cyc <= exp_done[k]);
                o = (cyc >= exp_done[k]);
                if (busy_v[k] !== b || ov_v[k] !== o) hs[k] = 1'b0;
            end
            if (mode == 1 && cyc == 5) begin
                start = 1'b1;
                sat = ~sat;
                set_rand_img();
            end
            if (mode == 2 && cyc == 11) start = 1'b1;
            if (mode == 3 && cyc == 6) begin
                #2;
                rst = 1'b0;
                #1;
                check({tag, " busy"}, 128'(busy_v), 128'(0));
                check({tag, " done"}, 128'(done_v), 128'(0));
                check({tag, " out_valid"}, 128'(ov_v), 128'(0));
                check({tag, " res4"}, 128'(r4), 128'(0));
                check({tag, " res6"}, r6, 128'(0));
                @(negedge clk);
                rst = 1'b1;
                return;
            end
        end
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s done_cycle[%0d]", tag, k),
                  128'(first[k]), 128'(exp_done[k]));
            check($sformatf("%s done_pulses[%0d]", tag, k),
                  128'(cnt[k]), 128'(1));
            check($sformatf("%s handshake[%0d]", tag, k),
                  128'(hs[k]), 128'(1));
        end
        check({tag, " res_pes4"}, 128'(r4), 128'(e4[31:0]));
        check({tag, " res_pes1"}, 128'(r1), 128'(e4[31:0]));
        check({tag, " res_pes2"}, 128'(r2), 128'(e4[31:0]));
        check({tag, " res_pes3"}, 128'(r3), 128'(e4[31:0]));
        check({tag, " res_img6"}, r6, e6);
        check({tag, " res_shift3"}, 128'(rs), 128'(es[31:0]));
    endtask

    initial begin
        set_t1();
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 128'(busy_v), 128'(0));
        check("reset done", 128'(done_v), 128'(0));
        check("reset out_valid", 128'(ov_v), 128'(0));
        check("reset res4", 128'(r4), 128'(0));
        check("reset res6", r6, 128'(0));
        rst = 1'b1;

        set_t1();
        sat = 1'b0;
        run(0, "T1");
        check("T1 const", 128'(r4), 128'(32'h3B224A43));

        set_t1();
        run(2, "T1dn");

        set_all(255);
        sat = 1'b1;
        run(0, "T3sat");
        check("T3sat const4", 128'(r4), 128'(32'hFFFFFFFF));
        check("T3sat const6", r6, {16{8'hFF}});
        sat = 1'b0;
        run(0, "T3trunc");
        check("T3trunc const4", 128'(r4), 128'(32'h09090909));
        check("T3trunc const6", r6, {16{8'h09}});

        set_t1();
        sat = 1'b0;
        run(1, "T4");
        check("T4 const", 128'(r4), 128'(32'h3B224A43));

        set_t1();
        sat = 1'b0;
        run(3, "T5");
        set_t1();
        run(0, "T5re");
        check("T5re const", 128'(r4), 128'(32'h3B224A43));

        for (int t = 0; t < 4; t++) begin
            set_rand();
            sat = 1'($urandom_range(0, 1));
            run(0, $sformatf("T6r%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
